// File: rtl/rob_param_if.sv
// Issue channel between decoder and rob_param.
// master = decoder side, slave = reorder buffer side.
interface rob_param_if #(
  parameter int ROB_BIT = 3,
  parameter int XLEN    = 32,
  parameter int REG_BIT = 5
);
  logic               issue_valid;
  logic               issue_ready;
  logic [ROB_BIT-1:0] issue_tag;
  logic [1:0]         issue_kind;
  logic [REG_BIT-1:0] issue_rd;
  logic [XLEN-1:0]    issue_pc;
  logic [XLEN-1:0]    issue_value;
  logic               issue_pred_taken;
  logic [XLEN-1:0]    issue_br_target;

  modport master (
    output issue_valid, issue_kind, issue_rd,
    output issue_pc, issue_value,
    output issue_pred_taken, issue_br_target,
    input  issue_ready, issue_tag
  );

  modport slave (
    input  issue_valid, issue_kind, issue_rd,
    input  issue_pc, issue_value,
    input  issue_pred_taken, issue_br_target,
    output issue_ready, issue_tag
  );
endinterface

// File: rtl/rob_param.sv
// Parametrised reorder buffer: multi-CDB writeback, in-order retire, commit-time flush.
// Define ROB_PERF_EN to build the perf_commits/perf_flushes counters.
module rob_param #(
  parameter int ROB_BIT = 3,
  parameter int NUM_CDB = 2,
  parameter int XLEN    = 32,
  parameter int REG_BIT = 5
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       rdy_in,
  rob_param_if.slave                 io,
  input  logic [NUM_CDB-1:0]         cdb_valid,
  input  logic [NUM_CDB*ROB_BIT-1:0] cdb_tag,
  input  logic [NUM_CDB*XLEN-1:0]    cdb_value,
  input  logic [ROB_BIT-1:0]         q_tag1,
  input  logic [ROB_BIT-1:0]         q_tag2,
  output logic                       q_ready1,
  output logic                       q_ready2,
  output logic [XLEN-1:0]            q_value1,
  output logic [XLEN-1:0]            q_value2,
  output logic                       commit_valid,
  output logic                       commit_wr,
  output logic                       commit_store,
  output logic [REG_BIT-1:0]         commit_rd,
  output logic [ROB_BIT-1:0]         commit_tag,
  output logic [XLEN-1:0]            commit_value,
  output logic                       flush,
  output logic [XLEN-1:0]            flush_pc,
  output logic [ROB_BIT:0]           rob_count,
  output logic [31:0]                perf_commits,
  output logic [31:0]                perf_flushes
);
  localparam int DEPTH = 1 << ROB_BIT;
  localparam logic [1:0] K_REG = 2'd0;
  localparam logic [1:0] K_IMM = 2'd1;
  localparam logic [1:0] K_ST  = 2'd2;
  localparam logic [1:0] K_BR  = 2'd3;

  logic [DEPTH-1:0]   busy;
  logic [DEPTH-1:0]   ready;
  logic [DEPTH-1:0]   pred;
  logic [1:0]         kind  [DEPTH];
  logic [REG_BIT-1:0] rd    [DEPTH];
  logic [XLEN-1:0]    pc    [DEPTH];
  logic [XLEN-1:0]    value [DEPTH];
  logic [XLEN-1:0]    tgt   [DEPTH];

  logic [ROB_BIT-1:0] head;
  logic [ROB_BIT-1:0] tail;
  logic [ROB_BIT:0]   count;

  logic               full;
  logic               accept;
  logic               head_taken;
  logic [DEPTH-1:0]   hit;
  logic [XLEN-1:0]    hit_val [DEPTH];

  assign full = (count == (ROB_BIT+1)'(DEPTH));
  assign io.issue_ready = !full;
  assign io.issue_tag = tail;
  assign rob_count = count;
  assign accept = io.issue_valid && !full && rdy_in;

  // Scan channels high to low so the lowest index wins a tag clash.
  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      hit[e] = 1'b0;
      hit_val[e] = '0;
      for (int c = NUM_CDB - 1; c >= 0; c--) begin
        if (cdb_valid[c] &&
            cdb_tag[c*ROB_BIT +: ROB_BIT] == ROB_BIT'(e)) begin
          hit[e] = 1'b1;
          hit_val[e] = cdb_value[c*XLEN +: XLEN];
        end
      end
    end
  end

  assign q_ready1 = busy[q_tag1] && (ready[q_tag1] || hit[q_tag1]);
  assign q_ready2 = busy[q_tag2] && (ready[q_tag2] || hit[q_tag2]);
  assign q_value1 = !busy[q_tag1] ? '0 :
                    ready[q_tag1] ? value[q_tag1] :
                    hit[q_tag1]   ? hit_val[q_tag1] : '0;
  assign q_value2 = !busy[q_tag2] ? '0 :
                    ready[q_tag2] ? value[q_tag2] :
                    hit[q_tag2]   ? hit_val[q_tag2] : '0;

  assign head_taken = value[head][0];
  assign commit_valid = rdy_in && busy[head] && ready[head];
  assign commit_wr = commit_valid && rd[head] != '0 &&
                     (kind[head] == K_REG || kind[head] == K_IMM);
  assign commit_store = commit_valid && kind[head] == K_ST;
  assign commit_rd = commit_valid ? rd[head] : '0;
  assign commit_tag = commit_valid ? head : '0;
  assign commit_value = commit_valid ? value[head] : '0;
  assign flush = commit_valid && kind[head] == K_BR &&
                 head_taken != pred[head];
  assign flush_pc = !flush ? '0 :
                    head_taken ? tgt[head] : pc[head] + XLEN'(4);

  always_ff @(posedge clk_in) begin
    if (rst_in || (rdy_in && flush)) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      busy  <= '0;
      ready <= '0;
      pred  <= '0;
      for (int e = 0; e < DEPTH; e++) begin
        kind[e]  <= K_REG;
        rd[e]    <= '0;
        pc[e]    <= '0;
        value[e] <= '0;
        tgt[e]   <= '0;
      end
    end else if (rdy_in) begin
      for (int e = 0; e < DEPTH; e++) begin
        if (busy[e] && !ready[e] && hit[e]) begin
          ready[e] <= 1'b1;
          value[e] <= hit_val[e];
        end
      end
      if (commit_valid) begin
        busy[head]  <= 1'b0;
        ready[head] <= 1'b0;
        value[head] <= '0;
        head <= head + 1'b1;
      end
      if (accept) begin
        busy[tail]  <= 1'b1;
        ready[tail] <= io.issue_kind == K_IMM;
        kind[tail]  <= io.issue_kind;
        rd[tail]    <= io.issue_rd;
        pc[tail]    <= io.issue_pc;
        value[tail] <= io.issue_kind == K_IMM ? io.issue_value : '0;
        pred[tail]  <= io.issue_pred_taken;
        tgt[tail]   <= io.issue_br_target;
        tail <= tail + 1'b1;
      end
      if (accept && !commit_valid) count <= count + 1'b1;
      else if (!accept && commit_valid) count <= count - 1'b1;
    end
  end

`ifdef ROB_PERF_EN
  logic [31:0] n_commits;
  logic [31:0] n_flushes;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      n_commits <= '0;
      n_flushes <= '0;
    end else begin
      if (commit_valid) n_commits <= n_commits + 1'b1;
      if (flush) n_flushes <= n_flushes + 1'b1;
    end
  end

  assign perf_commits = n_commits;
  assign perf_flushes = n_flushes;
`else
  assign perf_commits = '0;
  assign perf_flushes = '0;
`endif
endmodule
